maj_serial_adder: RTL and testbench



---
 rtl/maj_pkg.sv | 16 +
 rtl/maj3_full_adder.sv | 22 ++
 rtl/maj_serial_adder.sv | 116 +++++++++++
 tb/tb_maj_serial_adder.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/maj_pkg.sv
// Shared definitions for the bit-serial majority adder.
//   state_t : control FSM states (IDLE, ADD, DONE)
//   maj3    : three-input majority, the only gate used by the adder cell
package maj_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

endpackage

// File: rtl/maj3_full_adder.sv
// One-bit full adder built only from three-input majority terms and inverters.
// Ports:
//   x, y : operand bits
//   c    : carry in
//   s    : sum bit
//   co   : carry out
module maj3_full_adder
    import maj_pkg::*;
(
    input  logic x,
    input  logic y,
    input  logic c,
    output logic s,
    output logic co
);

    // The sum is a majority of three majorities. Each inner term inverts
    // exactly one input, so the outer vote reproduces x ^ y ^ c.
    assign co = maj3(x, y, c);
    assign s  = maj3(maj3(~x, y, c), maj3(x, y, ~c), maj3(x, ~y, c));

endmodule

// File: rtl/maj_serial_adder.sv
// Bit-serial LSB-first adder that uses a single majority full-adder cell.
// It accepts WIDTH-bit operands through a valid/ready handshake, then spends
// WIDTH cycles on the add, one bit per cycle. It presents sum/cout until the
// consumer accepts them.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid, in_ready  : operand handshake (a, b, cin)
//   out_valid, out_ready: result handshake (sum, cout)
//   sum, cout           : registered result, held until the next result lands
module maj_serial_adder
    import maj_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state, state_next;
    logic [WIDTH-1:0] a_sr, b_sr, sum_sr, sum_shift, sum_q;
    logic             carry, cout_q, out_valid_q;
    logic [CNT_W-1:0] cnt;
    logic             last;
    logic             cell_s, cell_co;

    assign last = (cnt == CNT_W'(WIDTH - 1));

    maj3_full_adder u_fa (
        .x  (a_sr[0]),
        .y  (b_sr[0]),
        .c  (carry),
        .s  (cell_s),
        .co (cell_co)
    );

    // The new sum bit enters at the MSB. After WIDTH shifts, bit 0 has
    // reached position 0. The shift form also works when WIDTH == 1.
    assign sum_shift = (sum_sr >> 1) | (WIDTH'(cell_s) << (WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (in_valid)  state_next = ADD;
            ADD:     if (last)      state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr        <= '0;
            b_sr        <= '0;
            sum_sr      <= '0;
            carry       <= 1'b0;
            cnt         <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= cin;
                        cnt   <= '0;
                    end
                end
                ADD: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    sum_sr <= sum_shift;
                    carry  <= cell_co;
                    if (last) begin
                        // Load the output registers on the way into DONE so
                        // that they stay stable for the whole DONE state.
                        sum_q       <= sum_shift;
                        cout_q      <= cell_co;
                        out_valid_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) out_valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // While rst is high, hold in_ready low so no operand looks accepted
    // in the reset cycle.
    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_maj_serial_adder.sv
module tb_maj_serial_adder;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       in_valid, in_ready, out_valid, out_ready, cin, cout;
    logic [3:0] a, b, sum;

    logic       v1_in_valid, v1_in_ready, v1_out_valid, v1_out_ready, v1_cin, v1_cout;
    logic [0:0] v1_a, v1_b, v1_sum;

    maj_serial_adder #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout)
    );

    maj_serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(v1_in_valid), .in_ready(v1_in_ready),
        .a(v1_a), .b(v1_b), .cin(v1_cin),
        .out_valid(v1_out_valid), .out_ready(v1_out_ready),
        .sum(v1_sum), .cout(v1_cout)
    );

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [3:0] s;
        logic       co;
    } vec_t;

    vec_t vt[8];
    int   total  = 0;
    int   passed = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // The op starts in the current cycle (cycle 0). out_ready stays 1.
    // After it ends, the bench is in the cycle where in_ready is back, so
    // calls chain back-to-back.
    task automatic run_op(input logic [3:0] ta, input logic [3:0] tb, input logic tc,
                          input logic [3:0] es, input logic ec, input string tag);
        int n;
        chk({tag, "_in_ready_pre"}, in_ready, 1);
        a = ta; b = tb; cin = tc; in_valid = 1'b1;
        tick;
        in_valid = 1'b0; a = 4'h0; b = 4'h0; cin = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin
            tick;
            n++;
        end
        chk({tag, "_latency"}, n, 5);
        chk({tag, "_sum"}, sum, es);
        chk({tag, "_cout"}, cout, ec);
        tick;
        chk({tag, "_in_ready_post"}, in_ready, 1);
        chk({tag, "_out_valid_post"}, out_valid, 0);
    endtask

    initial begin
        int n;
        logic [4:0] ref5;

        vt[0] = '{4'h5, 4'h3, 1'b0, 4'h8, 1'b0};
        vt[1] = '{4'hF, 4'h1, 1'b0, 4'h0, 1'b1};
        vt[2] = '{4'hF, 4'hF, 1'b1, 4'hF, 1'b1};
        vt[3] = '{4'h0, 4'h0, 1'b0, 4'h0, 1'b0};
        vt[4] = '{4'hA, 4'h5, 1'b1, 4'h0, 1'b1};
        vt[5] = '{4'h9, 4'h9, 1'b0, 4'h2, 1'b1};
        vt[6] = '{4'h7, 4'h8, 1'b1, 4'h0, 1'b1};
        vt[7] = '{4'h6, 4'h3, 1'b1, 4'hA, 1'b0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = 4'h0; b = 4'h0; cin = 1'b0;
        v1_in_valid = 1'b0; v1_out_ready = 1'b1; v1_a = 1'b0; v1_b = 1'b0; v1_cin = 1'b0;

        // Reset state
        tick; tick;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_w1_out_valid", v1_out_valid, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_w1_in_ready", v1_in_ready, 1);

        // Directed table, issued back-to-back
        for (int i = 0; i < 8; i++)
            run_op(vt[i].a, vt[i].b, vt[i].cin, vt[i].s, vt[i].co, $sformatf("vec%0d", i));

        // Backpressure: hold the result for 3 cycles and ignore an operand pulse
        out_ready = 1'b0;
        a = 4'h5; b = 4'h3; cin = 1'b0; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin
            tick;
            n++;
        end
        chk("bp_latency", n, 5);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp_hold%0d_valid", i), out_valid, 1);
            chk($sformatf("bp_hold%0d_sum", i), sum, 4'h8);
            chk($sformatf("bp_hold%0d_cout", i), cout, 0);
            chk($sformatf("bp_hold%0d_in_ready", i), in_ready, 0);
            if (i == 1) begin
                a = 4'h1; b = 4'h0; in_valid = 1'b1;
            end
            tick;
            in_valid = 1'b0; a = 4'h0;
        end
        chk("bp_still_valid", out_valid, 1);
        chk("bp_still_sum", sum, 4'h8);
        out_ready = 1'b1;
        tick;
        chk("bp_done_valid", out_valid, 0);
        chk("bp_done_in_ready", in_ready, 1);
        chk("bp_sum_kept", sum, 4'h8);
        chk("bp_cout_kept", cout, 0);
        run_op(4'h3, 4'h4, 1'b0, 4'h7, 1'b0, "bp_after");

        // Reset asserted in the 2nd ADD cycle of 7+6
        a = 4'h7; b = 4'h6; cin = 1'b0; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        tick;
        rst = 1'b1;
        #1;
        chk("midrst_in_ready_low", in_ready, 0);
        tick;
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_sum", sum, 0);
        chk("midrst_cout", cout, 0);
        chk("midrst_in_ready", in_ready, 1);
        run_op(4'h2, 4'h2, 1'b0, 4'h4, 1'b0, "after_rst");

        // Exhaustive WIDTH=4 against the reference a+b+cin
        for (int ai = 0; ai < 16; ai++)
            for (int bi = 0; bi < 16; bi++)
                for (int ci = 0; ci < 2; ci++) begin
                    ref5 = 5'(ai) + 5'(bi) + 5'(ci);
                    run_op(4'(ai), 4'(bi), 1'(ci), ref5[3:0], ref5[4],
                           $sformatf("exh_%0h_%0h_%0d", ai, bi, ci));
                end

        // WIDTH=1: single ADD cycle
        chk("w1_in_ready_pre", v1_in_ready, 1);
        v1_a = 1'b1; v1_b = 1'b1; v1_cin = 1'b1; v1_in_valid = 1'b1;
        tick;
        v1_in_valid = 1'b0;
        n = 1;
        while (!v1_out_valid && n < 20) begin
            tick;
            n++;
        end
        chk("w1_latency", n, 2);
        chk("w1_sum", v1_sum, 1);
        chk("w1_cout", v1_cout, 1);
        tick;
        chk("w1_in_ready_post", v1_in_ready, 1);
        chk("w1_out_valid_post", v1_out_valid, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
